// File: rtl/dsp_div_iterative.sv
// -----------------------------------------------------------------------------
// dsp_div_iterative
//
// Purpose:
//   Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU
//   instructions. It sits beside the ALU in EX and handles one operation at a
//   time. The pipeline stalls while busy is high. Operand sign handling and
//   the RISC-V divide-by-zero and signed-overflow results are produced here,
//   so the pipeline never has to special-case them.
//
// Ports:
//   clk       in   1     single clock, all state updates on the rising edge
//   reset     in   1     synchronous, active-high; aborts any running op
//   start     in   1     request, sampled only while idle (busy==0)
//   op        in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend  in   XLEN  rs1 operand, sampled together with start
//   divisor   in   XLEN  rs2 operand, sampled together with start
//   busy      out  1     high from the cycle after accept through the done cycle
//   done      out  1     single-cycle pulse; result is valid from this cycle on
//   result    out  XLEN  quotient (op[1]=0) or remainder (op[1]=1)
//
// Timing:
//   Normal ops: accept in cycle 0, XLEN RUN cycles, done in cycle XLEN+1.
//   Divide-by-zero and signed overflow skip RUN: done in cycle 1.
//   A start in the cycle right after done is accepted, which gives a
//   back-to-back throughput of one op per XLEN+2 cycles.
// -----------------------------------------------------------------------------
module dsp_div_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_q,  state_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [XLEN-1:0] quo_q,    quo_d;
  logic [XLEN-1:0] rem_q,    rem_d;
  logic [XLEN-1:0] dvs_q,    dvs_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            negQuo_q, negQuo_d;
  logic            negRem_q, negRem_d;
  logic            remSel_q, remSel_d;

  // ---------------------------------------------------------------------------
  // Accept-time operand conditioning. Only ops with op[0]==0 are signed; for
  // those a set MSB means a negative operand whose magnitude is its 2's
  // complement. The most negative value maps to 2^(XLEN-1), which still fits
  // as an unsigned XLEN-bit magnitude.
  // ---------------------------------------------------------------------------
  logic            isSigned;
  logic            dividendNeg;
  logic            divisorNeg;
  logic [XLEN-1:0] dividendMag;
  logic [XLEN-1:0] divisorMag;
  logic            divByZero;
  logic            signedOverflow;

  assign isSigned       = ~op[0];
  assign dividendNeg    = isSigned & dividend[XLEN-1];
  assign divisorNeg     = isSigned & divisor[XLEN-1];
  assign dividendMag    = dividendNeg ? -dividend : dividend;
  assign divisorMag     = divisorNeg  ? -divisor  : divisor;
  assign divByZero      = (divisor == '0);
  assign signedOverflow = isSigned & (dividend == MIN_NEG) & (divisor == '1);

  // ---------------------------------------------------------------------------
  // One restoring step. The partial remainder shifts in the next dividend bit
  // from the top of the quotient register while the quotient register shifts
  // left and collects result bits at the bottom. Before the shift the partial
  // remainder is made only of already-consumed dividend bits (fewer than
  // XLEN), so the shifted value always fits in XLEN bits; only the trial
  // subtraction needs the extra bit to expose its borrow.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] remShift;
  logic [XLEN:0]   trial;
  logic            trialNeg;
  logic [XLEN-1:0] stepRem;
  logic [XLEN-1:0] stepQuo;

  assign remShift = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
  assign trial    = {1'b0, remShift} - {1'b0, dvs_q};
  assign trialNeg = trial[XLEN];
  assign stepRem  = trialNeg ? remShift : trial[XLEN-1:0];
  assign stepQuo  = {quo_q[XLEN-2:0], ~trialNeg};

  // ---------------------------------------------------------------------------
  // Sign fix-up of the final step's outputs. The result register is loaded on
  // the edge that enters FIN, so the signed result is already visible in the
  // FIN cycle together with done.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] quoSigned;
  logic [XLEN-1:0] remSigned;
  logic [XLEN-1:0] finalResult;

  assign quoSigned   = negQuo_q ? -stepQuo : stepQuo;
  assign remSigned   = negRem_q ? -stepRem : stepRem;
  assign finalResult = remSel_q ? remSigned : quoSigned;

  // ---------------------------------------------------------------------------
  // Next-state and output logic. Every register holds by default. In IDLE a
  // start latches the conditioned operands; divide-by-zero and signed overflow
  // produce their architectural results at once and jump straight to FIN. RUN
  // counts XLEN-1 down to 0 and loads the result on the last step.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    negQuo_d = negQuo_q;
    negRem_d = negRem_q;
    remSel_d = remSel_q;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          remSel_d = op[1];
          negQuo_d = dividendNeg ^ divisorNeg;
          negRem_d = dividendNeg;
          dvs_d    = divisorMag;
          quo_d    = dividendMag;
          rem_d    = '0;
          count_d  = CW'(XLEN - 1);
          if (divByZero) begin
            // Quotient is all ones, remainder is the untouched dividend.
            result_d = op[1] ? dividend : '1;
            state_d  = FIN;
          end else if (signedOverflow) begin
            // -2^(XLEN-1) / -1: quotient wraps to the dividend, remainder 0.
            result_d = op[1] ? '0 : dividend;
            state_d  = FIN;
          end else begin
            state_d  = RUN;
          end
        end
      end

      RUN: begin
        busy  = 1'b1;
        quo_d = stepQuo;
        rem_d = stepRem;
        if (count_q == '0) begin
          result_d = finalResult;
          state_d  = FIN;
        end else begin
          count_d  = count_q - CW'(1);
        end
      end

      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset takes priority over everything, including a start
  // in the same cycle, and clears the visible result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
      negQuo_q <= 1'b0;
      negRem_q <= 1'b0;
      remSel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      negQuo_q <= negQuo_d;
      negRem_q <= negRem_d;
      remSel_q <= remSel_d;
    end
  end

  assign result = result_q;

endmodule
